mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/wisc_mem_pkg.sv | 39 +++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/fill_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_mem_pkg.sv
// Shared types and sizing for the I/D memory arbiter.
package wisc_mem_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned WORDS   = 8;
  localparam int unsigned MEM_LAT = 4;
  localparam int unsigned CNT_W   = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // One memory-side access as driven onto the bus.
  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Block-aligned base: clears the byte offset inside a block of WORDS 2-byte words.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(2 * WORDS - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and fill-port signals of the I/D memory arbiter.
interface mem_arbiter_if;
  import wisc_mem_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] fill_data;
  logic [CNT_W-1:0]  fill_word;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_done;
  logic              d_done;
  logic              stall;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           i_fill_we, d_fill_we, i_done, d_done, stall
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
           i_fill_we, d_fill_we, i_done, d_done, stall
  );

endinterface

// File: rtl/fill_counter.sv
// Issue / receive word counters for one block fill.
module fill_counter
  import wisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc_issue,
  input  logic             inc_rx,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic             issue_last_c,
  output logic             rx_last_c
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      issue_cnt <= '0;
      rx_cnt    <= '0;
    end else begin
      if (inc_issue) issue_cnt <= issue_cnt + CNT_W'(1);
      if (inc_rx)    rx_cnt    <= rx_cnt + CNT_W'(1);
    end
  end

  assign issue_last_c = (issue_cnt == CNT_W'(WORDS - 1));
  assign rx_last_c    = (rx_cnt == CNT_W'(WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-side write-through onto one memory port.
module mem_arbiter
  import wisc_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic              issuing;
  logic [ADDR_W-1:0] base;
  mem_cmd_t          cmd;
  logic              i_done_q;
  logic              d_done_q;

  logic              i_pend_c;
  logic              d_pend_c;
  logic              grant_c;
  logic              grant_wr_c;
  owner_t            grant_side_c;
  logic [ADDR_W-1:0] grant_base_c;
  logic              rx_hit_c;
  logic              inc_issue_c;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic              issue_last_c;
  logic              rx_last_c;

  fill_counter u_fill_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (grant_c),
    .inc_issue    (inc_issue_c),
    .inc_rx       (rx_hit_c),
    .issue_cnt    (issue_cnt),
    .rx_cnt       (rx_cnt),
    .issue_last_c (issue_last_c),
    .rx_last_c    (rx_last_c)
  );

  // A requester sees its done pulse while still holding req; mask it so it is not re-granted.
  always_comb begin
    i_pend_c     = bus.i_req & ~i_done_q;
    d_pend_c     = bus.d_req & ~d_done_q;
    grant_c      = (state == ST_IDLE) & (i_pend_c | d_pend_c);
    grant_side_c = OWN_I;
    if (i_pend_c && d_pend_c) begin
      grant_side_c = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (d_pend_c) begin
      grant_side_c = OWN_D;
    end
    grant_wr_c   = (grant_side_c == OWN_D) & bus.d_wr;
    grant_base_c = block_base((grant_side_c == OWN_D) ? bus.d_addr : bus.i_addr);
    rx_hit_c     = (state == ST_FILL) & bus.mem_valid;
    inc_issue_c  = (state == ST_FILL) & issuing & ~issue_last_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      issuing    <= 1'b0;
      base       <= '0;
      cmd        <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_c) begin
            owner      <= grant_side_c;
            last_grant <= grant_side_c;
            if (grant_wr_c) begin
              state <= ST_WRITE;
              cmd   <= '{en: 1'b1, wr: 1'b1, addr: bus.d_addr, wdata: bus.d_wdata};
            end else begin
              state   <= ST_FILL;
              base    <= grant_base_c;
              issuing <= 1'b1;
              cmd     <= '{en: 1'b1, wr: 1'b0, addr: grant_base_c, wdata: '0};
            end
          end
        end
        ST_FILL: begin
          if (issuing) begin
            if (issue_last_c) begin
              issuing <= 1'b0;
              cmd     <= '0;
            end else begin
              cmd.addr <= word_addr(base, issue_cnt + CNT_W'(1));
            end
          end
          if (rx_hit_c && rx_last_c) begin
            state <= ST_IDLE;
            if (owner == OWN_D) d_done_q <= 1'b1;
            else                i_done_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          state    <= ST_IDLE;
          cmd      <= '0;
          d_done_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          issuing <= 1'b0;
          cmd     <= '0;
        end
      endcase
    end
  end

  assign bus.mem_en    = cmd.en;
  assign bus.mem_wr    = cmd.wr;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.fill_data = bus.mem_rdata;
  assign bus.fill_word = rx_cnt;
  assign bus.i_fill_we = rx_hit_c & (owner == OWN_I);
  assign bus.d_fill_we = rx_hit_c & (owner == OWN_D);
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.stall     = (state != ST_IDLE) | i_pend_c | d_pend_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
  import wisc_mem_pkg::*;

  localparam logic [15:0] RD_XOR = 16'h5A5A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stray = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory: each read returns MEM_LAT cycles later with data = addr ^ RD_XOR.
  logic [MEM_LAT-1:0] vpipe = '0;
  logic [15:0]        apipe [MEM_LAT];

  always @(posedge clk) begin
    vpipe    <= {vpipe[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
    apipe[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) apipe[i] <= apipe[i-1];
  end

  assign bus.mem_valid = vpipe[MEM_LAT-1] | stray;
  assign bus.mem_rdata = apipe[MEM_LAT-1] ^ RD_XOR;

  typedef struct {
    string       name;
    logic        i_req;
    logic        d_req;
    logic        d_wr;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    int          drop_at;
    logic        exp_wr;
    logic [15:0] exp_addr;
    int          exp_n_en;
    int          exp_i_we;
    int          exp_d_we;
    logic        exp_d_side;
    int          exp_done_at;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input string name, input logic i_req, input logic d_req,
                              input logic d_wr, input logic [15:0] i_addr,
                              input logic [15:0] d_addr, input logic [15:0] d_wdata,
                              input int drop_at, input logic exp_wr,
                              input logic [15:0] exp_addr, input int exp_n_en,
                              input int exp_i_we, input int exp_d_we,
                              input logic exp_d_side, input int exp_done_at);
    vec_t v;
    v.name = name;       v.i_req = i_req;       v.d_req = d_req;     v.d_wr = d_wr;
    v.i_addr = i_addr;   v.d_addr = d_addr;     v.d_wdata = d_wdata; v.drop_at = drop_at;
    v.exp_wr = exp_wr;   v.exp_addr = exp_addr; v.exp_n_en = exp_n_en;
    v.exp_i_we = exp_i_we; v.exp_d_we = exp_d_we; v.exp_d_side = exp_d_side;
    v.exp_done_at = exp_done_at;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int   n_en = 0, n_we = 0, n_iwe = 0, n_dwe = 0;
    int   first_en = -1, done_at = -1;
    int   wr_err = 0, addr_err = 0, data_err = 0, word_err = 0, stall_err = 0, quiet_err = 0;
    logic done_side = 1'b0;
    @(posedge clk); #1;
    bus.i_req = v.i_req;   bus.i_addr = v.i_addr;
    bus.d_req = v.d_req;   bus.d_wr = v.d_wr;
    bus.d_addr = v.d_addr; bus.d_wdata = v.d_wdata;
    #1;
    check({v.name, ":stall_t0"}, 32'(bus.stall), 32'd1);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.mem_en) begin
        if (n_en == 0) first_en = c;
        if (bus.mem_wr !== v.exp_wr) wr_err++;
        if (bus.mem_addr !== (v.exp_wr ? v.exp_addr : v.exp_addr + 16'(2 * n_en))) addr_err++;
        if (v.exp_wr && bus.mem_wdata !== v.d_wdata) data_err++;
        n_en++;
      end
      if (bus.i_fill_we || bus.d_fill_we) begin
        if (bus.fill_word !== CNT_W'(n_we)) word_err++;
        if (bus.fill_data !== ((v.exp_addr + 16'(2 * n_we)) ^ RD_XOR)) data_err++;
        n_we++;
      end
      if (bus.i_fill_we) n_iwe++;
      if (bus.d_fill_we) n_dwe++;
      if (bus.i_done || bus.d_done) begin
        done_at   = c;
        done_side = bus.d_done;
        if (bus.i_done && bus.d_done) quiet_err++;
        if (bus.stall) stall_err++;
        drive_idle();
        break;
      end
      if (!bus.stall) stall_err++;
      if (v.drop_at == c) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    if (done_at < 0) drive_idle();
    for (int q = 0; q < 3; q++) begin
      @(posedge clk); #1;
      if (bus.i_done || bus.d_done || bus.mem_en || bus.i_fill_we || bus.d_fill_we || bus.stall)
        quiet_err++;
    end
    check({v.name, ":first_en"},  32'(first_en),  32'd1);
    check({v.name, ":n_en"},      32'(n_en),      32'(v.exp_n_en));
    check({v.name, ":wr_err"},    32'(wr_err),    32'd0);
    check({v.name, ":addr_err"},  32'(addr_err),  32'd0);
    check({v.name, ":data_err"},  32'(data_err),  32'd0);
    check({v.name, ":word_err"},  32'(word_err),  32'd0);
    check({v.name, ":i_fill_we"}, 32'(n_iwe),     32'(v.exp_i_we));
    check({v.name, ":d_fill_we"}, 32'(n_dwe),     32'(v.exp_d_we));
    check({v.name, ":done_at"},   32'(done_at),   32'(v.exp_done_at));
    check({v.name, ":done_side"}, 32'(done_side), 32'(v.exp_d_side));
    check({v.name, ":stall_err"}, 32'(stall_err), 32'd0);
    check({v.name, ":quiet_err"}, 32'(quiet_err), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":mem_en"},    32'(bus.mem_en),    32'd0);
    check({tag, ":mem_wr"},    32'(bus.mem_wr),    32'd0);
    check({tag, ":mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, ":mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, ":fill_word"}, 32'(bus.fill_word), 32'd0);
    check({tag, ":fill_we"},   32'({bus.i_fill_we, bus.d_fill_we}), 32'd0);
    check({tag, ":done"},      32'({bus.i_done, bus.d_done}),       32'd0);
    check({tag, ":stall"},     32'(bus.stall),     32'd0);
  endtask

  // Reset asserted in cycle 6 of an I fill; late returns must be dropped.
  task automatic seq_reset_mid_fill();
    int err = 0;
    @(posedge clk); #1;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1236;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    check("midrst:en_t6", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("midrst_t7");
    for (int c = 7; c <= 12; c++) begin
      if (c > 7) begin
        @(posedge clk); #1;
      end
      stray = (c >= 11);
      #1;
      if (bus.i_fill_we || bus.d_fill_we || bus.i_done || bus.d_done || bus.mem_en) err++;
    end
    stray = 1'b0;
    check("midrst:stray_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("midrst:fill_word", 32'(bus.fill_word), 32'd0);
    check("midrst:stall", 32'(bus.stall), 32'd0);
  endtask

  // Both sides hold fill requests: grants alternate starting with D after reset.
  task automatic seq_tie();
    int          dc [4] = '{-1, -1, -1, -1};
    logic        ds [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          nd = 0, iwe = 0, dwe = 0, both = 0;
    logic [15:0] a1 = '0, a14 = '0;
    @(posedge clk); #1;
    bus.i_req  = 1'b1; bus.i_addr = 16'h0A0A;
    bus.d_req  = 1'b1; bus.d_wr   = 1'b0; bus.d_addr = 16'h0B0B;
    for (int c = 1; c <= 70 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (c == 1)  a1  = bus.mem_addr;
      if (c == 14) a14 = bus.mem_addr;
      iwe += int'(bus.i_fill_we);
      dwe += int'(bus.d_fill_we);
      if (bus.i_done && bus.d_done) both++;
      if (bus.i_done || bus.d_done) begin
        dc[nd] = c;
        ds[nd] = bus.d_done;
        nd++;
      end
    end
    drive_idle();
    check("tie:n_done",  32'(nd),   32'd4);
    check("tie:addr_t1", 32'(a1),   32'h0B00);
    check("tie:addr_t14", 32'(a14), 32'h0A00);
    check("tie:done0_at", 32'(dc[0]), 32'd13);
    check("tie:done1_at", 32'(dc[1]), 32'd26);
    check("tie:done2_at", 32'(dc[2]), 32'd39);
    check("tie:done3_at", 32'(dc[3]), 32'd52);
    check("tie:done0_d",  32'(ds[0]), 32'd1);
    check("tie:done1_d",  32'(ds[1]), 32'd0);
    check("tie:done2_d",  32'(ds[2]), 32'd1);
    check("tie:done3_d",  32'(ds[3]), 32'd0);
    check("tie:both",     32'(both),  32'd0);
    check("tie:i_we",     32'(iwe),   32'd16);
    check("tie:d_we",     32'(dwe),   32'd16);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    //          name               i  d  wr i_addr    d_addr    wdata     drop wr exp_addr  n_en iwe dwe d  done
    vecs[0] = mk("i_fill",         1, 0, 0, 16'h1236, 16'h0000, 16'h0000, 0,   0, 16'h1230, 8,   8,  0,  0, 13);
    vecs[1] = mk("d_fill",         0, 1, 0, 16'h0000, 16'h0F0F, 16'h0000, 0,   0, 16'h0F00, 8,   0,  8,  1, 13);
    vecs[2] = mk("d_write",        0, 1, 1, 16'h0000, 16'h0040, 16'hBEEF, 0,   1, 16'h0040, 1,   0,  0,  1, 2);
    vecs[3] = mk("i_fill_top",     1, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 0,   0, 16'hFFF0, 8,   8,  0,  0, 13);
    vecs[4] = mk("d_write_odd",    0, 1, 1, 16'h0000, 16'hFFFF, 16'h1234, 0,   1, 16'hFFFF, 1,   0,  0,  1, 2);
    vecs[5] = mk("i_drop_t3",      1, 0, 0, 16'h2468, 16'h0000, 16'h0000, 3,   0, 16'h2460, 8,   8,  0,  0, 13);
    vecs[6] = mk("d_fill_drop_t1", 0, 1, 0, 16'h0000, 16'h7FF8, 16'h0000, 1,   0, 16'h7FF0, 8,   0,  8,  1, 13);
    vecs[7] = mk("i_fill_dwr",     1, 0, 1, 16'h8009, 16'h0000, 16'h0000, 0,   0, 16'h8000, 8,   8,  0,  0, 13);
    vecs[8] = mk("d_write_drop",   0, 1, 1, 16'h0000, 16'h1111, 16'hCAFE, 1,   1, 16'h1111, 1,   0,  0,  1, 2);

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    seq_reset_mid_fill();
    run_vec(vecs[2]);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seq_tie();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
